// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I fetch-side types and constants.
//   rv32i_word    - 32-bit machine word
//   fetch_state_t - fetch FSM states (REQ, HOLD, DRAIN)
//   NOP_INSTR     - canonical NOP (addi x0, x0, 0)
//   word_align    - clears the two low bits of an address
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam rv32i_word NOP_INSTR = 32'h0000_0013;

    function automatic rv32i_word word_align(input rv32i_word addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_register.sv
// pc_register: loadable register with synchronous active-high reset.
//   clk   - clock
//   reset - synchronous reset, loads RESET_VAL
//   load  - capture d on the rising edge
//   d     - next value
//   q     - current value
module pc_register #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] value_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= RESET_VAL;
        end else if (load) begin
            value_q <= d;
        end
    end

    assign q = value_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with single outstanding read, stall buffer
// and redirect handling.
//   clk, reset                  - clock, synchronous active-high reset
//   stall                       - IF/ID cannot accept this cycle
//   redirect_valid, redirect_pc - taken branch/jump target from downstream
//   imem_read, imem_address     - instruction-memory request
//   imem_rdata, imem_resp       - instruction-memory response
//   if_pc, if_instr, if_valid   - payload for the IF/ID register
//   ifid_load, ifid_flush       - IF/ID load and clear strobes
module fetch_stage
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_valid,
    output logic        ifid_load,
    output logic        ifid_flush
);

    fetch_state_t state_q, state_d;
    rv32i_word    pc_q, pc_d;
    logic         pc_load;
    rv32i_word    req_addr_q, req_addr_d;
    rv32i_word    buf_instr_q, buf_instr_d;
    rv32i_word    buf_pc_q, buf_pc_d;
    rv32i_word    target;

    assign target = word_align(redirect_pc);

    pc_register #(
        .WIDTH     (32),
        .RESET_VAL (RESET_PC)
    ) u_pc (
        .clk   (clk),
        .reset (reset),
        .load  (pc_load),
        .d     (pc_d),
        .q     (pc_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= REQ;
            req_addr_q  <= RESET_PC;
            buf_instr_q <= NOP_INSTR;
            buf_pc_q    <= RESET_PC;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc_load      = 1'b0;
        req_addr_d   = req_addr_q;
        buf_instr_d  = buf_instr_q;
        buf_pc_d     = buf_pc_q;
        ifid_load    = 1'b0;
        ifid_flush   = 1'b0;
        if_valid     = 1'b0;
        if_pc        = req_addr_q;
        if_instr     = buf_instr_q;
        imem_read    = (state_q != HOLD);
        imem_address = req_addr_q;

        unique case (state_q)
            REQ: begin
                if (redirect_valid) begin
                    ifid_flush = 1'b1;
                    pc_d       = target;
                    pc_load    = 1'b1;
                    if (imem_resp) begin
                        req_addr_d = target;
                    end else begin
                        // Read at req_addr stays on the bus until it completes.
                        state_d = DRAIN;
                    end
                end else if (imem_resp) begin
                    if (!stall) begin
                        ifid_load  = 1'b1;
                        if_valid   = 1'b1;
                        if_instr   = imem_rdata;
                        if_pc      = req_addr_q;
                        req_addr_d = req_addr_q + 32'd4;
                        pc_d       = req_addr_q + 32'd4;
                        pc_load    = 1'b1;
                    end else begin
                        buf_instr_d = imem_rdata;
                        buf_pc_d    = req_addr_q;
                        state_d     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    ifid_flush = 1'b1;
                    req_addr_d = target;
                    pc_d       = target;
                    pc_load    = 1'b1;
                    state_d    = REQ;
                end else if (!stall) begin
                    ifid_load  = 1'b1;
                    if_valid   = 1'b1;
                    if_instr   = buf_instr_q;
                    if_pc      = buf_pc_q;
                    req_addr_d = buf_pc_q + 32'd4;
                    pc_d       = buf_pc_q + 32'd4;
                    pc_load    = 1'b1;
                    state_d    = REQ;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    ifid_flush = 1'b1;
                    pc_d       = target;
                    pc_load    = 1'b1;
                    // A stale read finishing in the same cycle must not leave
                    // us waiting for a response that will never arrive.
                    if (imem_resp) begin
                        req_addr_d = target;
                        state_d    = REQ;
                    end
                end else if (imem_resp) begin
                    req_addr_d = pc_q;
                    state_d    = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase

        if (reset) begin
            ifid_load  = 1'b0;
            if_valid   = 1'b0;
            ifid_flush = 1'b1;
            imem_read  = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0060;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        ifid_load;
    logic        ifid_flush;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_read      (imem_read),
        .imem_address   (imem_address),
        .imem_rdata     (imem_rdata),
        .imem_resp      (imem_resp),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_valid       (if_valid),
        .ifid_load      (ifid_load),
        .ifid_flush     (ifid_flush)
    );

    // Memory contents: each word is a fixed function of its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hCAFE_0000;
    endfunction

    // Instruction memory with random 1..3 cycle latency, one read at a time.
    logic        mem_pending;
    logic [31:0] mem_addr;
    int unsigned mem_delay;

    always @(posedge clk) begin
        if (reset) begin
            mem_pending <= 1'b0;
            mem_delay   <= 0;
        end else if (mem_pending) begin
            if (mem_delay == 0) mem_pending <= 1'b0;
            else                mem_delay   <= mem_delay - 1;
        end else if (imem_read) begin
            mem_pending <= 1'b1;
            mem_addr    <= imem_address;
            mem_delay   <= $urandom_range(0, 2);
        end
    end

    assign imem_resp  = mem_pending && (mem_delay == 0);
    assign imem_rdata = imem_resp ? mem_word(mem_addr) : 32'hDEAD_BEEF;

    // Reference model: the delivered stream is program order from the last
    // reset / redirect target, one word at a time, wrapping at 2^32.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] tail_pc;

    function automatic void refill();
        exp_t e;
        while (exp_q.size() < 16) begin
            e.pc    = tail_pc;
            e.instr = mem_word(tail_pc);
            exp_q.push_back(e);
            tail_pc = tail_pc + 32'd4;
        end
    endfunction

    function automatic void restart_stream(input logic [31:0] start);
        exp_q.delete();
        tail_pc = start & 32'hFFFF_FFFC;
        refill();
    endfunction

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned deliveries = 0;
    int unsigned idle = 0;
    logic        first_after_reset = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: sample mid-cycle, pop expectations on every IF/ID load.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1) begin
            check("reset_flush", {31'd0, ifid_flush}, 32'd1);
            check("reset_read",  {31'd0, imem_read},  32'd0);
            check("reset_valid", {31'd0, if_valid},   32'd0);
            check("reset_load",  {31'd0, ifid_load},  32'd0);
            idle = 0;
        end else if (reset === 1'b0) begin
            check("valid_eq_load", {31'd0, if_valid}, {31'd0, ifid_load});
            check("flush_eq_redirect", {31'd0, ifid_flush}, {31'd0, redirect_valid});
            if (redirect_valid) check("load_on_redirect", {31'd0, ifid_load}, 32'd0);
            if (stall)          check("load_under_stall", {31'd0, ifid_load}, 32'd0);
            if (mem_pending) begin
                check("read_held",  {31'd0, imem_read}, 32'd1);
                check("addr_stable", imem_address, mem_addr);
            end
            if (first_after_reset) begin
                check("first_read",  {31'd0, imem_read}, 32'd1);
                check("first_addr",  imem_address, RESET_PC);
                first_after_reset = 1'b0;
            end
            if (ifid_load) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_load", {31'd0, ifid_load}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("if_pc",    if_pc,    e.pc);
                    check("if_instr", if_instr, e.instr);
                end
                deliveries++;
                idle = 0;
            end else if (redirect_valid) begin
                idle = 0;
            end else begin
                idle++;
                if (idle > 80) begin
                    check("watchdog_progress", idle, 32'd0);
                    idle = 0;
                end
            end
        end
    end

    logic [31:0] targets [5] = '{32'h0000_0200, 32'h0000_0300, 32'h0000_0203,
                                 32'hFFFF_FFF8, 32'hFFFF_FFFC};

    initial begin
        int unsigned reset_cnt;
        logic        prev_redirect;
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        restart_stream(RESET_PC);
        reset_cnt      = 0;
        prev_redirect  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        first_after_reset = 1'b1;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #1;
            if (reset_cnt > 0) begin
                reset_cnt--;
                if (reset_cnt == 0) begin
                    reset = 1'b0;
                    first_after_reset = 1'b1;
                end
                continue;
            end
            if ($urandom_range(0, 249) == 0) begin
                reset          = 1'b1;
                reset_cnt      = $urandom_range(1, 3);
                stall          = 1'b0;
                redirect_valid = 1'b0;
                prev_redirect  = 1'b0;
                restart_stream(RESET_PC);
                continue;
            end
            stall = ($urandom_range(0, 2) == 0);
            // Redirects occasionally come in bursts to exercise DRAIN retargeting.
            if ($urandom_range(0, 19) == 0 || (prev_redirect && $urandom_range(0, 2) == 0)) begin
                redirect_valid = 1'b1;
                if ($urandom_range(0, 1) == 0)
                    redirect_pc = targets[$urandom_range(0, 4)];
                else
                    redirect_pc = $urandom;
                restart_stream(redirect_pc);
            end else begin
                redirect_valid = 1'b0;
                refill();
            end
            prev_redirect = redirect_valid;
        end

        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        check("min_deliveries", {31'd0, deliveries > 300}, 32'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
